// File: rtl/inst_sram_responder.sv
// Instruction SRAM slave: 1-cycle read latency, byte write enables, backdoor preload, sticky out-of-range flag.
// Optional access counters (rd_cnt/wr_cnt) are enabled by defining INST_SRAM_STATS_EN.
module inst_sram_responder #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE_PA = 32'h1fc00000,
  localparam int         AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sram_en,
  input  logic [3:0]    sram_wen,
  input  logic [31:0]   sram_addr,
  input  logic [31:0]   sram_wdata,
  output logic [31:0]   sram_rdata,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data,
`ifdef INST_SRAM_STATS_EN
  output logic          err_oor,
  output logic [31:0]   rd_cnt,
  output logic [31:0]   wr_cnt
`else
  output logic          err_oor
`endif
);

  localparam logic [31:0] WIN = 32'(DEPTH) << 2;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   pa;
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   base_word;
  logic [31:0]   merged;
  logic          port_wr;
  logic          port_rd;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          unused_ok;

  // Top three virtual address bits select the segment only; physical window is below them.
  assign pa        = {3'b000, sram_addr[28:0]};
  assign off       = pa - BASE_PA;
  assign in_range  = off < WIN;
  assign idx       = off[AW+1:2];
  assign port_wr   = sram_en && in_range && (sram_wen != 4'b0000);
  assign port_rd   = sram_en && in_range && (sram_wen == 4'b0000);
  assign unused_ok = ^{sram_addr[31:29], off[1:0]};

  // Port bytes override backdoor data, which overrides the stored word.
  always_comb begin
    base_word = mem[idx];
    if (ld_en && (ld_idx == idx)) base_word = ld_data;
    merged = base_word;
    for (int b = 0; b < 4; b++) begin
      if (sram_wen[b]) merged[8*b +: 8] = sram_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ld_en)   mem[ld_idx] <= ld_data;
      if (port_wr) mem[idx]    <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (sram_en) begin
      rdata_q <= in_range ? merged : 32'h0;
      if (!in_range) err_q <= 1'b1;
    end
  end

  assign sram_rdata = rdata_q;
  assign err_oor    = err_q;

`ifdef INST_SRAM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= 32'h0;
      wr_cnt <= 32'h0;
    end else begin
      if (port_rd && (rd_cnt != 32'hffffffff)) rd_cnt <= rd_cnt + 32'd1;
      if (port_wr && (wr_cnt != 32'hffffffff)) wr_cnt <= wr_cnt + 32'd1;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = port_rd;
`endif

endmodule

// File: tb/tb_inst_sram_responder.sv
// Self-checking bench for inst_sram_responder: directed steps plus randomized traffic vs. a word-array model.
module tb_inst_sram_responder;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1fc00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_data;
  logic        err_oor;
`ifdef INST_SRAM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  always #5 clk = ~clk;

  inst_sram_responder #(.DEPTH(DEPTH), .BASE_PA(BASE)) dut (
    .clk(clk), .reset(reset),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
`ifdef INST_SRAM_STATS_EN
    .err_oor(err_oor), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`else
    .err_oor(err_oor)
`endif
  );

  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] mdl_rdata;
  logic        mdl_err;
  logic [31:0] mdl_rd;
  logic [31:0] mdl_wr;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare just after the edge.
  task automatic cyc(input logic rst, input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic l_en, input logic [9:0] l_idx, input logic [31:0] l_data);
    logic [31:0] off;
    int i;
    reset = rst; sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    ld_en = l_en; ld_idx = l_idx; ld_data = l_data;
    @(posedge clk);
    if (rst) begin
      mdl_rdata = 32'h0; mdl_err = 1'b0; mdl_rd = 32'h0; mdl_wr = 32'h0;
    end else begin
      if (l_en) mdl_mem[l_idx] = l_data;
      if (en) begin
        off = (addr & 32'h1fffffff) - BASE;
        if (off < DEPTH * 4) begin
          i = int'(off >> 2);
          for (int b = 0; b < 4; b++)
            if (wen[b]) mdl_mem[i][8*b +: 8] = wdata[8*b +: 8];
          mdl_rdata = mdl_mem[i];
          if (wen == 4'b0) begin
            if (mdl_rd != 32'hffffffff) mdl_rd = mdl_rd + 1;
          end else begin
            if (mdl_wr != 32'hffffffff) mdl_wr = mdl_wr + 1;
          end
        end else begin
          mdl_rdata = 32'h0;
          mdl_err   = 1'b1;
        end
      end
    end
    #1;
    chk("rdata", sram_rdata, mdl_rdata);
    chk("err_oor", {31'b0, err_oor}, {31'b0, mdl_err});
`ifdef INST_SRAM_STATS_EN
    chk("rd_cnt", rd_cnt, mdl_rd);
    chk("wr_cnt", wr_cnt, mdl_wr);
`endif
  endtask

  function automatic logic [31:0] va(input int idx);
    logic [31:0] p;
    p = BASE + 32'(idx) * 4;
    return {3'($urandom), p[28:2], 2'($urandom)};
  endfunction

  initial begin
    mdl_rdata = 0; mdl_err = 0; mdl_rd = 0; mdl_wr = 0;
    reset = 1; sram_en = 0; sram_wen = 0; sram_addr = 0; sram_wdata = 0;
    ld_en = 0; ld_idx = 0; ld_data = 0;
    @(posedge clk); #1;

    // Reset state
    cyc(1, 0, 4'h0, 0, 0, 0, 0, 0);
    chk("reset_rdata", sram_rdata, 32'h0);
    chk("reset_err", {31'b0, err_oor}, 32'h0);

    // Preload the whole array through the backdoor
    for (int k = 0; k < DEPTH; k++) cyc(0, 0, 4'h0, 0, 0, 1, 10'(k), $urandom);

    // Writes during reset are suppressed on both ports
    cyc(1, 1, 4'hf, va(5), 32'hdeadbeef, 1, 10'd6, 32'hcafef00d);
    cyc(0, 1, 4'h0, va(5), 0, 0, 0, 0);
    cyc(0, 1, 4'h0, va(6), 0, 0, 0, 0);

    // 1: backdoor load then read word 0
    cyc(0, 0, 4'h0, 0, 0, 1, 10'd0, 32'h3c08bfc0);
    cyc(0, 1, 4'h0, 32'hbfc00000, 0, 0, 0, 0);
    chk("t1_read", sram_rdata, 32'h3c08bfc0);

    // 2: rdata holds while idle, even across backdoor writes to the same word
    cyc(0, 0, 4'h0, 0, 0, 1, 10'd1, 32'h11111111);
    cyc(0, 1, 4'h0, 32'hbfc00004, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 4'h0, 32'hbfc00004, $urandom, 1, 10'd1, $urandom);
      chk("t2_hold", sram_rdata, 32'h11111111);
    end

    // 3: byte-masked write, write-first result, then readback
    cyc(0, 0, 4'h0, 0, 0, 1, 10'd2, 32'haabbccdd);
    cyc(0, 1, 4'b0101, 32'h9fc00008, 32'h11223344, 0, 0, 0);
    chk("t3_wr_first", sram_rdata, 32'haa22cc44);
    cyc(0, 1, 4'h0, 32'h9fc00008, 0, 0, 0, 0);
    chk("t3_readback", sram_rdata, 32'haa22cc44);

    // 4: just past the window, then an in-range read with the flag still set
    cyc(0, 1, 4'h0, 32'hbfc00000 + DEPTH * 4, 0, 0, 0, 0);
    chk("t4_oor_rdata", sram_rdata, 32'h0);
    chk("t4_oor_err", {31'b0, err_oor}, 32'h1);
    cyc(0, 1, 4'h0, 32'hbfc00000, 0, 0, 0, 0);
    chk("t4_after_rdata", sram_rdata, 32'h3c08bfc0);
    chk("t4_after_err", {31'b0, err_oor}, 32'h1);
    cyc(0, 1, 4'h0, BASE - 4, 0, 0, 0, 0);

    // 5: port and backdoor collide on one word
    cyc(0, 1, 4'b1000, 32'hbfc0000c, 32'h0, 1, 10'd3, 32'hffffffff);
    chk("t5_merge", sram_rdata, 32'h00ffffff);
    cyc(0, 1, 4'h0, 32'hbfc0000c, 0, 0, 0, 0);
    chk("t5_readback", sram_rdata, 32'h00ffffff);
    cyc(0, 1, 4'h0, 32'hbfc00010, 0, 1, 10'd4, 32'h12345678);
    chk("t5_rd_fwd", sram_rdata, 32'h12345678);

    // Randomized traffic, including occasional resets and random out-of-window addresses
    for (int k = 0; k < 600; k++) begin
      logic [3:0] w;
      logic [31:0] a;
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      a = ($urandom_range(0, 4) != 0) ? va($urandom_range(0, DEPTH - 1)) : $urandom;
      cyc($urandom_range(0, 79) == 0, 1'($urandom), w, a, $urandom,
          1'($urandom), 10'($urandom_range(0, DEPTH - 1)), $urandom);
    end

`ifdef INST_SRAM_STATS_EN
    // 6: counters ignore out-of-range and backdoor accesses, and clear on reset
    cyc(1, 0, 4'h0, 0, 0, 0, 0, 0);
    cyc(0, 1, 4'h0, va(10), 0, 0, 0, 0);
    cyc(0, 1, 4'h3, va(11), $urandom, 0, 0, 0);
    cyc(0, 1, 4'h0, va(12), 0, 0, 0, 0);
    cyc(0, 1, 4'h0, 32'hbfc00000 + DEPTH * 4, 0, 0, 0, 0);
    cyc(0, 0, 4'h0, 0, 0, 1, 10'd13, $urandom);
    cyc(0, 1, 4'hf, va(14), $urandom, 0, 0, 0);
    cyc(0, 1, 4'h0, va(15), 0, 0, 0, 0);
    chk("t6_rd_cnt", rd_cnt, 32'd3);
    chk("t6_wr_cnt", wr_cnt, 32'd2);
    cyc(1, 1, 4'h0, va(16), 0, 0, 0, 0);
    chk("t6_rst_rd", rd_cnt, 32'd0);
    chk("t6_rst_wr", wr_cnt, 32'd0);
    chk("t6_rst_rdata", sram_rdata, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
